// File: rtl/sim_mem_pkg.sv
// ---------------------------------------------------------------------------
// sim_mem_pkg
// Shared types and constants for the simulation memory / peripheral slave.
//   state_e      : request FSM states (idle, wait-state countdown, response)
//   dec_e        : address-decode result (memory, console, exit, error)
//   DefConAddr   : default console byte write address
//   DefExitAddr  : default exit/status register address
//   decode_addr(): classifies a latched word address
// ---------------------------------------------------------------------------
package sim_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        DecMem,
        DecCon,
        DecExit,
        DecErr
    } dec_e;

    localparam logic [31:0] DefConAddr  = 32'h1000_0000;
    localparam logic [31:0] DefExitAddr = 32'h1000_0004;

    // Memory takes priority over the peripheral addresses, so an oversized
    // memory simply shadows them. mem_bytes is 33 bits so that a full 4 GiB
    // comparison stays exact.
    function automatic dec_e decode_addr(
        input logic [29:0] word,
        input logic [32:0] mem_bytes,
        input logic [29:0] con_word,
        input logic [29:0] exit_word
    );
        if ({1'b0, word, 2'b00} < mem_bytes) begin
            return DecMem;
        end
        if (word == con_word) begin
            return DecCon;
        end
        if (word == exit_word) begin
            return DecExit;
        end
        return DecErr;
    endfunction

endpackage

// File: rtl/sim_mem_fifo.sv
// ---------------------------------------------------------------------------
// sim_mem_fifo
// Small synchronous FIFO used as the console byte stream buffer.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data : write request and data; accepted when not full, or when
//                    full and a pop happens in the same cycle
//   i_pop          : read request; ignored when empty
//   o_data         : head entry (valid while !o_empty)
//   o_full/o_empty : occupancy flags
// ---------------------------------------------------------------------------
module sim_mem_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    always_comb begin
        w_empty   = (r_wptr == r_rptr);
        w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_do_pop  = i_pop && !w_empty;
        // A pop in the same cycle frees the slot the push needs.
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/sim_mem_slave.sv
// ---------------------------------------------------------------------------
// sim_mem_slave
// Simulation memory and peripheral slave on the picorv32 native memory bus.
// Adds programmable wait states, a back-pressured console byte stream, a
// sticky exit/status register and sticky out-of-range error reporting.
// Memory contents are never reset; the enclosing bench preloads them.
//
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_mem_valid/i_mem_instr : request strobe / fetch flag (flag unused)
//   i_mem_addr/wdata/wstrb  : byte address, write data, byte strobes (0=read)
//   o_mem_ready/o_mem_rdata : one-cycle response strobe and read data
//   o_con_valid/o_con_data  : console byte stream, consumed on i_con_ready
//   o_exit_valid/o_exit_code: sticky exit flag and last exit value
//   o_bus_error             : sticky out-of-range access flag
//
// Build option: define SIM_MEM_RANDWAIT_EN to add 0..3 pseudo-random wait
// cycles per request from a 16-bit LFSR.
// ---------------------------------------------------------------------------
module sim_mem_slave
    import sim_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 4194304,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] CON_ADDR    = DefConAddr,
    parameter logic [31:0] EXIT_ADDR   = DefExitAddr,
    parameter int unsigned CON_DEPTH   = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_con_valid,
    output logic [7:0]  o_con_data,
    input  logic        i_con_ready,
    output logic        o_exit_valid,
    output logic [31:0] o_exit_code,
    output logic        o_bus_error
);

    localparam int unsigned MemWords = MEM_BYTES / 4;
    localparam int unsigned IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int unsigned CntW     = $clog2(WAIT_CYCLES + 5);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic [CntW-1:0]   w_wait_load;
    logic              w_accept;

    logic [29:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_ready;
    logic [31:0]       r_rdata;
    logic              r_exit_valid;
    logic [31:0]       r_exit_code;
    logic              r_bus_error;
    logic [31:0]       r_mem [MemWords];

    dec_e              w_dec;
    logic [IdxW-1:0]   w_idx;
    logic              w_is_write;
    logic              w_con_wr;
    logic              w_con_push;
    logic              w_con_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_stall;
    logic              w_commit;
    logic              w_unused_inputs;

    assign w_unused_inputs = i_mem_instr ^ (^i_mem_addr[1:0]);

`ifdef SIM_MEM_RANDWAIT_EN
    logic [15:0] r_lfsr;

    // x^16 + x^14 + x^13 + x^11 + 1, stepped once per accepted request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_wait_load = CntW'(WAIT_CYCLES) + CntW'(r_lfsr[1:0]);
`else
    assign w_wait_load = CntW'(WAIT_CYCLES);
`endif

    // Decode and response control, all on the latched request.
    always_comb begin
        w_dec      = decode_addr(r_addr, 33'(MEM_BYTES), CON_ADDR[31:2], EXIT_ADDR[31:2]);
        w_idx      = r_addr[IdxW-1:0];
        w_is_write = |r_wstrb;
        w_con_wr   = (w_dec == DecCon) && w_is_write;
        w_con_pop  = o_con_valid && i_con_ready;
        // A console write may complete into a full FIFO only if a byte leaves now.
        w_stall    = (r_state == StResp) && w_con_wr && w_fifo_full && !w_con_pop;
        w_commit   = (r_state == StResp) && !w_stall;
        w_con_push = w_commit && w_con_wr;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_mem_valid) begin
                    w_accept = 1'b1;
                    if (w_wait_load == '0) begin
                        w_state_nxt = StResp;
                    end else begin
                        w_state_nxt = StWait;
                        w_cnt_nxt   = w_wait_load;
                    end
                end
            end
            StWait: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= CntW'(1)) begin
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                if (!w_stall) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_ready      <= 1'b0;
            r_rdata      <= '0;
            r_exit_valid <= 1'b0;
            r_exit_code  <= '0;
            r_bus_error  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_commit;
            if (w_accept) begin
                r_addr  <= i_mem_addr[31:2];
                r_wdata <= i_mem_wdata;
                r_wstrb <= i_mem_wstrb;
            end
            if (w_commit) begin
                unique case (w_dec)
                    DecMem:  r_rdata <= r_mem[w_idx];
                    DecCon:  r_rdata <= {31'b0, w_fifo_full};
                    DecExit: r_rdata <= r_exit_code;
                    default: r_rdata <= '0;
                endcase
                if ((w_dec == DecExit) && w_is_write) begin
                    r_exit_code  <= r_wdata;
                    r_exit_valid <= 1'b1;
                end
                if (w_dec == DecErr) begin
                    r_bus_error <= 1'b1;
                end
            end
        end
    end

    // Memory array has no reset; a reset on the commit edge drops the write.
    always_ff @(posedge i_clk) begin
        if (w_commit && !i_reset && (w_dec == DecMem)) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    sim_mem_fifo #(
        .DEPTH (CON_DEPTH),
        .WIDTH (8)
    ) u_con_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_con_push),
        .i_data  (r_wdata[7:0]),
        .i_pop   (w_con_pop),
        .o_data  (o_con_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_con_valid  = !w_fifo_empty;
    assign o_mem_ready  = r_ready;
    assign o_mem_rdata  = r_rdata;
    assign o_exit_valid = r_exit_valid;
    assign o_exit_code  = r_exit_code;
    assign o_bus_error  = r_bus_error;

endmodule

// File: tb/tb_sim_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_sim_mem_slave
// Scoreboard bench for sim_mem_slave (WAIT_CYCLES=2, CON_DEPTH=2, 4 MiB).
// The driver issues bus requests and pushes the expected response from a
// behavioural model; independent monitors compare bus responses and console
// bytes as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_sim_mem_slave;

    localparam int unsigned MemBytes   = 4194304;
    localparam int unsigned WaitCycles = 2;
    localparam int unsigned ConDepth   = 2;
    localparam logic [31:0] ConAddr    = 32'h1000_0000;
    localparam logic [31:0] ExitAddr   = 32'h1000_0004;
`ifdef SIM_MEM_RANDWAIT_EN
    localparam int Slack = 3;
`else
    localparam int Slack = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        con_ready = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        bus_error;

    always #5 clk = ~clk;

    sim_mem_slave #(
        .MEM_BYTES   (MemBytes),
        .WAIT_CYCLES (WaitCycles),
        .CON_ADDR    (ConAddr),
        .EXIT_ADDR   (ExitAddr),
        .CON_DEPTH   (ConDepth)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_mem_valid  (mem_valid),
        .i_mem_instr  (mem_instr),
        .i_mem_addr   (mem_addr),
        .i_mem_wdata  (mem_wdata),
        .i_mem_wstrb  (mem_wstrb),
        .o_mem_ready  (mem_ready),
        .o_mem_rdata  (mem_rdata),
        .o_con_valid  (con_valid),
        .o_con_data   (con_data),
        .i_con_ready  (con_ready),
        .o_exit_valid (exit_valid),
        .o_exit_code  (exit_code),
        .o_bus_error  (bus_error)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          chk;
        int          ready_cyc;
        bit          exact;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  con_q[$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] m_exit_code = '0;
    bit          m_exit_valid = 1'b0;
    bit          m_bus_err = 1'b0;
    bit          con_hint_en = 1'b0;
    bit          con_hint_full = 1'b0;
    int          con_mode = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        mon_e;
    logic [7:0]  mon_b;
    logic [31:0] pool [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Console consumer: 0 = stalled, 1 = always ready, otherwise random.
    always @(posedge clk) begin
        #1;
        case (con_mode)
            0:       con_ready = 1'b0;
            1:       con_ready = 1'b1;
            default: con_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference behaviour of one access, evaluated at issue time.
    function automatic void model(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb, output logic [31:0] rd,
                                  output bit chk, output bit exact);
        logic [31:0] wa;
        int unsigned w;
        logic [31:0] cur;
        wa    = {addr[31:2], 2'b00};
        w     = int'(addr[31:2]);
        rd    = '0;
        chk   = 1'b0;
        exact = 1'b1;
        if (wa < MemBytes) begin
            if (wstrb == 4'h0) begin
                chk = ref_mem.exists(w);
                if (chk) rd = ref_mem[w];
            end else if (ref_mem.exists(w) || wstrb == 4'hF) begin
                cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                end
                ref_mem[w] = cur;
            end
        end else if (wa == ConAddr) begin
            if (wstrb != 4'h0) begin
                con_q.push_back(wdata[7:0]);
                exact = 1'b0;
            end else begin
                chk = con_hint_en;
                rd  = {31'b0, con_hint_full};
            end
        end else if (wa == ExitAddr) begin
            if (wstrb != 4'h0) begin
                m_exit_code  = wdata;
                m_exit_valid = 1'b1;
            end else begin
                chk = 1'b1;
                rd  = m_exit_code;
            end
        end else begin
            m_bus_err = 1'b1;
            chk       = (wstrb == 4'h0);
        end
    endfunction

    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input string name);
        exp_t        e;
        logic [31:0] rd;
        bit          chk;
        bit          exact;
        bit          done;
        @(negedge clk);
        model(addr, wdata, wstrb, rd, chk, exact);
        e.rdata     = rd;
        e.chk       = chk;
        e.exact     = exact;
        e.name      = name;
        e.ready_cyc = cyc + 1 + WaitCycles + 1;
        sb_q.push_back(e);
        mem_valid = 1'b1;
        mem_instr = 1'($urandom_range(0, 1));
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = mem_ready;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: mem_ready=0 after 100 cycles, required 1", name);
            sb_q.delete();
        end else begin
            check({name, "_bus_error"}, 32'(bus_error), 32'(m_bus_err));
            check({name, "_exit_valid"}, 32'(exit_valid), 32'(m_exit_valid));
            check({name, "_exit_code"}, exit_code, m_exit_code);
        end
    endtask

    // Bus response monitor.
    always @(negedge clk) begin
        if (mem_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_ready: mem_ready=1 at cycle %0d, no request pending", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (cyc < mon_e.ready_cyc || (mon_e.exact && cyc > mon_e.ready_cyc + Slack)) begin
                    failures++;
                    $display("FAIL %s_latency: ready at cycle %0d, expected cycle %0d",
                             mon_e.name, cyc, mon_e.ready_cyc);
                end
                if (mon_e.chk) check({mon_e.name, "_rdata"}, mem_rdata, mon_e.rdata);
            end
        end
    end

    // Console stream monitor.
    always @(negedge clk) begin
        if (!reset && con_valid && con_ready) begin
            if (con_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL con_spurious: byte 0x%02h emitted, none expected", con_data);
            end else begin
                mon_b = con_q.pop_front();
                check("con_byte", 32'(con_data), 32'(mon_b));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_ready"}, 32'(mem_ready), 32'(0));
        check({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        check({tag, "_con_valid"}, 32'(con_valid), 32'(0));
        check({tag, "_exit_valid"}, 32'(exit_valid), 32'(0));
        check({tag, "_exit_code"}, exit_code, 32'h0);
        check({tag, "_bus_error"}, 32'(bus_error), 32'(0));
    endtask

    task automatic drain_console(input string tag);
        con_mode = 1;
        for (int i = 0; i < 100 && con_q.size() != 0; i++) @(negedge clk);
        check({tag, "_pending_bytes"}, 32'(con_q.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Wait-state read and byte-lane write.
        xfer(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, "pre_100");
        xfer(32'h0000_0100, 32'h0, 4'h0, "rd_100");
        xfer(32'h0000_0200, 32'h1122_3344, 4'hF, "pre_200");
        xfer(32'h0000_0200, 32'h00AA_0000, 4'b0100, "bw_200");
        xfer(32'h0000_0202, 32'h0, 4'h0, "rd_200");
        xfer(32'h0000_0300, 32'h1234_5678, 4'hF, "pre_300");
        xfer(MemBytes - 4, 32'hCAFE_F00D, 4'hF, "pre_top");
        xfer(MemBytes - 4, 32'h0, 4'h0, "rd_top");

        // Console back-pressure with a two-entry FIFO.
        con_mode      = 0;
        con_hint_en   = 1'b1;
        con_hint_full = 1'b0;
        repeat (2) @(negedge clk);
        xfer(ConAddr, 32'h0, 4'h0, "con_rd_empty");
        xfer(ConAddr, 32'h48, 4'h1, "con_h");
        xfer(ConAddr, 32'h69, 4'h1, "con_i");
        con_hint_full = 1'b1;
        xfer(ConAddr, 32'h0, 4'h0, "con_rd_full");
        con_hint_en = 1'b0;
        fork
            xfer(ConAddr, 32'h21, 4'h1, "con_bang");
            begin
                repeat (8) begin
                    @(negedge clk);
                    check("con_stall_ready", 32'(mem_ready), 32'(0));
                end
                con_mode = 1;
            end
        join
        drain_console("con_directed");

        // Exit register.
        xfer(ExitAddr, 32'h0000_002A, 4'hF, "exit_wr");
        @(negedge clk);
        check("exit_valid_after", 32'(exit_valid), 32'(m_exit_valid));
        check("exit_code_after", exit_code, m_exit_code);
        xfer(ExitAddr, 32'h0, 4'h0, "exit_rd");

        // Out-of-range read just past the end of memory.
        xfer(MemBytes, 32'h0, 4'h0, "oor_rd");
        repeat (5) @(negedge clk);
        check("oor_sticky", 32'(bus_error), 32'(m_bus_err));

        // Randomised traffic.
        con_mode = 2;
        pool[0] = MemBytes - 4;
        pool[1] = 32'h0;
        for (int i = 2; i < 8; i++) pool[i] = 32'($urandom_range(0, MemBytes / 4 - 1)) << 2;
        for (int i = 0; i < 8; i++) xfer(pool[i], $urandom, 4'hF, "rnd_init");
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            a  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if (op <= 3) begin
                xfer(a, $urandom, 4'h0, "rnd_rd");
            end else if (op <= 6) begin
                xfer(a, $urandom, 4'($urandom_range(1, 15)), "rnd_wr");
            end else if (op == 7) begin
                xfer(ConAddr, $urandom, 4'($urandom_range(1, 15)), "rnd_con");
            end else if (op == 8) begin
                xfer(ExitAddr, $urandom, 4'($urandom_range(0, 1) * 15), "rnd_exit");
            end else begin
                a = ($urandom_range(0, 1) == 0) ? (32'h0040_0000 | (32'($urandom_range(0, 4095)) << 2))
                                                : (32'h1000_0008 | (32'($urandom_range(0, 3)) << 2));
                xfer(a, $urandom, 4'($urandom_range(0, 1) * 15), "rnd_oor");
            end
        end
        drain_console("rnd");

        // Reset while the write to 0x300 is still counting wait states.
        con_mode = 0;
        repeat (2) @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0300;
        mem_wdata = 32'h0000_0055;
        mem_wstrb = 4'hF;
        @(negedge clk);
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        reset        = 1'b0;
        m_exit_code  = '0;
        m_exit_valid = 1'b0;
        m_bus_err    = 1'b0;
        con_q.delete();
        repeat (4) @(negedge clk);
        check_reset_outputs("mid_wait_reset");
        xfer(32'h0000_0300, 32'h0, 4'h0, "rd_300_after_reset");

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
